// File: rtl/dmem_param.sv
// -----------------------------------------------------------------------------
// dmem_param -- parametrised single-port synchronous data memory
//
// Data memory for the Harvard CPU data path. It sits between the load/store
// unit and the data address space. After every reset a hardware sweep writes
// zero to each word. While the sweep runs, ready is low. After the sweep the
// block accepts one request per cycle and never stalls. Reads are fully
// pipelined, and rvalid arrives RD_LAT cycles after the accept edge.
//
// Parameters:
//   DW     data word width in bits
//   AW     address width in bits
//   DEPTH  number of words, 1 <= DEPTH <= 2**AW
//   RD_LAT read latency from accept edge to rvalid, 1 or 2
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   req     in   request valid
//   we      in   1 = write, 0 = read (sampled with req)
//   addr    in   [AW-1:0] word address
//   wdata   in   [DW-1:0] write data
//   ready   out  request can be accepted this cycle
//   rvalid  out  one-cycle pulse, rdata holds a read result
//   rdata   out  [DW-1:0] read data, holds while rvalid is low
//   err     out  one-cycle pulse, accepted request had addr >= DEPTH
//   perr    out  parity mismatch on a read, pulses with rvalid
//
// Optional feature: define DMEM_PARITY_EN to store one even-parity bit per
// word and check it on reads. When the macro is undefined, perr is tied to 0.
// -----------------------------------------------------------------------------
module dmem_param #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          perr
);

    // Index width of the storage array. It is only ever used after an
    // in-range check, so dropping the upper address bits is safe.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The sweep counter is one bit wider than the address. This lets
    // DEPTH == 2**AW be represented and compared without wrapping.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_L  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   clr_cnt;
    logic [IW-1:0] clr_idx;
    logic [IW-1:0] addr_idx;
    logic          in_range;
    logic          accept;
    logic          acc_rd;
    logic          acc_wr_ok;
    logic          par_bad;

    logic [DW-1:0] mem [0:DEPTH-1];

`ifdef DMEM_PARITY_EN
    logic          mem_par [0:DEPTH-1];
`endif

    // Stage 1 of the read pipeline. Its registers are loaded at the accept edge.
    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_perr;

    assign clr_idx   = clr_cnt[IW-1:0];
    assign addr_idx  = addr[IW-1:0];
    assign in_range  = ({1'b0, addr} < DEPTH_L);
    assign accept    = req && ready;
    assign acc_rd    = accept && !we;
    assign acc_wr_ok = accept && we && in_range;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // flop samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (clr_cnt == LAST_L) state_nxt = ST_IDLE;
            ST_IDLE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        unique case (state)
            ST_CLEAR: ready = 1'b0;
            ST_IDLE:  ready = 1'b1;
            default:  ready = 1'b0;
        endcase
    end

    // Clear-sweep counter. It restarts from zero on every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + ONE_L;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset. A reset would stop it from mapping onto
    // RAM. The post-reset sweep zeroes it one word per cycle instead.
    // A read issued the cycle after a write therefore already sees the new
    // word, and no bypass path is needed.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (acc_wr_ok) begin
            mem[addr_idx] <= wdata;
        end
    end

`ifdef DMEM_PARITY_EN
    // The stored bit makes the XOR of data and parity even. Cleared words
    // hold parity 0, which is consistent with all-zero data.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem_par[clr_idx] <= 1'b0;
        end else if (acc_wr_ok) begin
            mem_par[addr_idx] <= ^wdata;
        end
    end

    // Out-of-range reads never flag a parity error.
    assign par_bad = in_range && ((^mem[addr_idx]) != mem_par[addr_idx]);
`else
    assign par_bad = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read pipeline stage 1 and error pulse
    // -------------------------------------------------------------------------
    // s1_data only loads on an accepted read. When it drives rdata directly,
    // rdata therefore holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_perr  <= 1'b0;
            err      <= 1'b0;
        end else begin
            s1_valid <= acc_rd;
            err      <= accept && !in_range;
            if (acc_rd) begin
                s1_data <= in_range ? mem[addr_idx] : '0;
                s1_perr <= par_bad;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline output stage, selected by RD_LAT
    // -------------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_valid;
            logic [DW-1:0] s2_data;
            logic          s2_perr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_perr  <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                        s2_perr <= s1_perr;
                    end
                end
            end

            assign rvalid = s2_valid;
            assign rdata  = s2_data;
            assign perr   = s2_valid && s2_perr;
        end else begin : g_lat1
            assign rvalid = s1_valid;
            assign rdata  = s1_data;
            assign perr   = s1_valid && s1_perr;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_param.sv
// -----------------------------------------------------------------------------
// tb_dmem_param -- directed bench for dmem_param
//
// Two instances share one stimulus stream:
//   dut_a : DEPTH=256, RD_LAT=1 (full address space)
//   dut_b : DEPTH=200, RD_LAT=2 (out-of-range addresses exist)
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_dmem_param;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;

    logic       ready_a, rvalid_a, err_a, perr_a;
    logic [7:0] rdata_a;
    logic       ready_b, rvalid_b, err_b, perr_b;
    logic [7:0] rdata_b;

    int checks   = 0;
    int failures = 0;

    dmem_param #(.DW(8), .AW(8), .DEPTH(256), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a),
        .err(err_a), .perr(perr_a)
    );

    dmem_param #(.DW(8), .AW(8), .DEPTH(200), .RD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b),
        .err(err_b), .perr(perr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at a falling edge, then move to the next
    // falling edge. The rising edge in between is the accept edge.
    task automatic drive(input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Wait for the clear sweep to finish on dut_a (the longer one). The cycle
    // limit is bounded so the bench cannot hang.
    task automatic wait_clear(output int na, output int nb);
        na = 0;
        nb = -1;
        while (!ready_a && na < 400) begin
            @(negedge clk);
            na++;
            if (ready_b && nb < 0) nb = na;
            // Stop the request before dut_b can accept it.
            if (na == 150) req = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int na;
        int nb;

        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;
        repeat (2) @(negedge clk);

        // ---- reset state ----
        chk1("rst_ready_a", ready_a, 1'b0);
        chk1("rst_rvalid_a", rvalid_a, 1'b0);
        chk8("rst_rdata_a", rdata_a, 8'h00);
        chk1("rst_err_a", err_a, 1'b0);
        chk1("rst_perr_a", perr_a, 1'b0);
        chk1("rst_ready_b", ready_b, 1'b0);
        chk1("rst_rvalid_b", rvalid_b, 1'b0);
        chk1("rst_err_b", err_b, 1'b0);

        // ---- clear sweep: a write of 0xFF to addr 5 is held during the sweep and must be ignored ----
        req   = 1'b1;
        we    = 1'b1;
        addr  = 8'h05;
        wdata = 8'hFF;
        rst_n = 1'b1;
        wait_clear(na, nb);
        chki("clear_cycles_a", na, 256);
        chki("clear_cycles_b", nb, 200);
        chk1("clear_no_err_a", err_a, 1'b0);

        // ---- read addr 5 after the sweep: data is zero ----
        drive(1'b1, 1'b0, 8'h05, 8'h00);
        chk1("rd5_rvalid_a", rvalid_a, 1'b1);
        chk8("rd5_rdata_a", rdata_a, 8'h00);
        chk1("rd5_rvalid_b_early", rvalid_b, 1'b0);
        idle();
        chk1("rd5_rvalid_a_off", rvalid_a, 1'b0);
        chk1("rd5_rvalid_b", rvalid_b, 1'b1);
        chk8("rd5_rdata_b", rdata_b, 8'h00);
        idle();
        chk1("rd5_rvalid_b_off", rvalid_b, 1'b0);

        // ---- write then read the next cycle (read-after-write) ----
        drive(1'b1, 1'b1, 8'h03, 8'hA5);
        chk1("wr3_no_rvalid_a", rvalid_a, 1'b0);
        drive(1'b1, 1'b0, 8'h03, 8'h00);
        chk1("raw_rvalid_a", rvalid_a, 1'b1);
        chk8("raw_rdata_a", rdata_a, 8'hA5);
        chk1("raw_rvalid_b_early", rvalid_b, 1'b0);
        idle();
        chk1("raw_rvalid_a_off", rvalid_a, 1'b0);
        chk8("raw_rdata_a_hold", rdata_a, 8'hA5);
        chk1("raw_rvalid_b", rvalid_b, 1'b1);
        chk8("raw_rdata_b", rdata_b, 8'hA5);
        idle();

        // ---- back-to-back reads ----
        drive(1'b1, 1'b1, 8'h01, 8'h11);
        drive(1'b1, 1'b1, 8'h02, 8'h22);
        drive(1'b1, 1'b1, 8'h03, 8'h33);
        drive(1'b1, 1'b0, 8'h01, 8'h00);
        chk1("b2b1_rvalid_a", rvalid_a, 1'b1);
        chk8("b2b1_rdata_a", rdata_a, 8'h11);
        drive(1'b1, 1'b0, 8'h02, 8'h00);
        chk1("b2b2_rvalid_a", rvalid_a, 1'b1);
        chk8("b2b2_rdata_a", rdata_a, 8'h22);
        chk1("b2b1_rvalid_b", rvalid_b, 1'b1);
        chk8("b2b1_rdata_b", rdata_b, 8'h11);
        drive(1'b1, 1'b0, 8'h03, 8'h00);
        chk1("b2b3_rvalid_a", rvalid_a, 1'b1);
        chk8("b2b3_rdata_a", rdata_a, 8'h33);
        chk1("b2b2_rvalid_b", rvalid_b, 1'b1);
        chk8("b2b2_rdata_b", rdata_b, 8'h22);
        idle();
        chk1("b2b_end_rvalid_a", rvalid_a, 1'b0);
        chk1("b2b3_rvalid_b", rvalid_b, 1'b1);
        chk8("b2b3_rdata_b", rdata_b, 8'h33);
        idle();
        chk1("b2b_end_rvalid_b", rvalid_b, 1'b0);

        // ---- out of range on dut_b (addr 210 >= 200), in range on dut_a ----
        drive(1'b1, 1'b1, 8'd210, 8'h7E);
        chk1("oor_wr_err_b", err_b, 1'b1);
        chk1("oor_wr_err_a", err_a, 1'b0);
        idle();
        chk1("oor_wr_err_b_off", err_b, 1'b0);
        drive(1'b1, 1'b0, 8'd210, 8'h00);
        chk1("oor_rd_err_b", err_b, 1'b1);
        chk1("oor_rd_rvalid_a", rvalid_a, 1'b1);
        chk8("oor_rd_rdata_a", rdata_a, 8'h7E);
        idle();
        chk1("oor_rd_err_b_off", err_b, 1'b0);
        chk1("oor_rd_rvalid_b", rvalid_b, 1'b1);
        chk8("oor_rd_rdata_b", rdata_b, 8'h00);
        chk1("oor_rd_perr_b", perr_b, 1'b0);
        idle();
        drive(1'b1, 1'b1, 8'd199, 8'h42);
        chk1("last_wr_err_b", err_b, 1'b0);
        drive(1'b1, 1'b0, 8'd199, 8'h00);
        chk8("last_rd_rdata_a", rdata_a, 8'h42);
        idle();
        chk1("last_rd_rvalid_b", rvalid_b, 1'b1);
        chk8("last_rd_rdata_b", rdata_b, 8'h42);
        chk1("last_rd_err_b", err_b, 1'b0);
        idle();

        // ---- reset in the middle of a read ----
        drive(1'b1, 1'b1, 8'h09, 8'h5A);
        req  = 1'b1;
        we   = 1'b0;
        addr = 8'h09;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk1("mid_rst_rvalid_a", rvalid_a, 1'b0);
        chk8("mid_rst_rdata_a", rdata_a, 8'h00);
        chk1("mid_rst_ready_a", ready_a, 1'b0);
        @(negedge clk);
        chk1("mid_rst_rvalid_b", rvalid_b, 1'b0);
        chk8("mid_rst_rdata_b", rdata_b, 8'h00);
        @(negedge clk);
        chk1("mid_rst_rvalid_b2", rvalid_b, 1'b0);
        rst_n = 1'b1;
        wait_clear(na, nb);
        chki("reclear_cycles_a", na, 256);
        chki("reclear_cycles_b", nb, 200);
        drive(1'b1, 1'b0, 8'h09, 8'h00);
        chk1("reclr_rvalid_a", rvalid_a, 1'b1);
        chk8("reclr_rdata_a", rdata_a, 8'h00);
        idle();
        chk1("reclr_rvalid_b", rvalid_b, 1'b1);
        chk8("reclr_rdata_b", rdata_b, 8'h00);
        idle();

`ifdef DMEM_PARITY_EN
        // ---- parity: flip stored bit 0 of addr 4 ----
        drive(1'b1, 1'b1, 8'h04, 8'h0F);
        drive(1'b1, 1'b1, 8'h06, 8'h33);
        dut_a.mem[4] = 8'h0E;
        dut_b.mem[4] = 8'h0E;
        drive(1'b1, 1'b0, 8'h04, 8'h00);
        chk1("par_rvalid_a", rvalid_a, 1'b1);
        chk1("par_perr_a", perr_a, 1'b1);
        chk8("par_rdata_a", rdata_a, 8'h0E);
        drive(1'b1, 1'b0, 8'h06, 8'h00);
        chk1("par_ok_perr_a", perr_a, 1'b0);
        chk1("par_perr_b", perr_b, 1'b1);
        idle();
        chk1("par_ok_perr_b", perr_b, 1'b0);
        chk8("par_ok_rdata_b", rdata_b, 8'h33);
        idle();
`else
        chk1("noparity_perr_a", perr_a, 1'b0);
        chk1("noparity_perr_b", perr_b, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_param.md
Name: dmem_param

Overview:
- Parametrised single-port synchronous data memory for the Harvard CPU data path; next generation of the 8x8 data memory.
- Replaces the bidirectional data bus with separate write and read buses and a req/ready/rvalid handshake.
- Adds configurable width, depth and read latency, a hardware clear sweep after reset, and out-of-range detection.
- Sits between the CPU load/store unit and the data address space.

Parameters:
- DW, 8, data word width in bits.
- AW, 8, address width in bits.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**AW.
- RD_LAT, 1, read latency in cycles from accept to rvalid; legal values 1 or 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  1  request valid.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  AW  word address.
- wdata  input  DW  write data.
- ready  output  1  block can accept a request this cycle.
- rvalid  output  1  one-cycle pulse: rdata holds read result.
- rdata  output  DW  read data.
- err  output  1  one-cycle pulse: accepted request had addr >= DEPTH.
- perr  output  1  parity error on read; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ready=0, rvalid=0, rdata=0, err=0, perr=0.
  - Read pipeline valid bits cleared.
  - FSM forced to CLEAR, clear counter = 0.
- FSM CLEAR:
  - Each cycle writes 0 to mem[clr_cnt], then clr_cnt += 1.
  - The write at clr_cnt = DEPTH-1 moves the FSM to IDLE.
  - The sweep takes exactly DEPTH cycles after rst_n deasserts; ready=0 throughout; req is ignored.
- FSM IDLE:
  - ready=1.
  - A request is accepted when req && ready on a rising edge.
  - IDLE is the only post-clear state; the block never stalls.
- Accepted write (we=1, addr<DEPTH):
  - mem[addr] <= wdata at that edge.
  - No rvalid pulse.
- Accepted read (we=0, addr<DEPTH):
  - rdata = mem[addr]; rvalid=1 for exactly one cycle, RD_LAT cycles after the accept edge.
  - Fully pipelined: one accept per cycle. N back-to-back reads give N consecutive rvalid pulses, in order.
- Read-after-write:
  - A read accepted the cycle after a write to the same address returns the new data.
  - The array is written at the accept edge, so no bypass is needed.
- rdata holds its last value while rvalid=0.
- Out of range (addr >= DEPTH, only possible when DEPTH < 2**AW):
  - err pulses 1 cycle after accept; memory is unchanged.
  - A read still produces an rvalid pulse at RD_LAT, with rdata=0.
- Width rules:
  - Widths of addr and wdata are exact; no truncation or extension inside the block.
  - clr_cnt width is AW+1 so DEPTH = 2**AW terminates correctly.
- Reset mid-operation:
  - In-flight reads are discarded and no rvalid is produced for them.
  - The clear sweep restarts from address 0, and all contents are zeroed again.
- we and wdata are don't-care when the request is not accepted.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from wdata on write; the clear sweep writes parity 0.
  - On read, stored parity is checked against the data. perr pulses together with rvalid on mismatch; rdata is still returned.
  - Out-of-range reads give perr=0.
- Not defined:
  - No parity storage; perr is tied to 0.

Test Plan:
- Reset release, DEPTH=256 -> ready stays 0 for 256 cycles, then goes 1. A read of addr 0x05 returns rdata=0x00 with rvalid after RD_LAT.
- Write 0xA5 to addr 0x03, next cycle read addr 0x03 -> RD_LAT=1: rvalid and rdata=0xA5 on the following cycle. Repeat with RD_LAT=2: rvalid one cycle later.
- Write 0x11/0x22/0x33 to addr 1/2/3, then read 1,2,3 back-to-back -> three consecutive rvalid pulses with 0x11, 0x22, 0x33 in order.
- DEPTH=200, AW=8: write 0x7E to addr 210 -> err pulse, no state change. Read 210 -> rvalid with rdata=0x00, err pulse. Read 199 -> normal data.
- Write 0x5A to addr 9, issue a read of 9, assert rst_n=0 before rvalid -> no rvalid, outputs 0. After the clear sweep, a read of 9 returns 0x00.
- DMEM_PARITY_EN: write 0x0F to addr 4, force the stored bit 0 to flip, read addr 4 -> rvalid with perr=1. Read an unforced word -> perr=0.
